// File: rtl/alu_issue_reg_pkg.sv
// Shared definitions for the D->E issue register: ALU opcodes, forward-select
// encoding and the hard-wired zero register index.
package alu_issue_reg_pkg;

    localparam int DW_DEF  = 32;
    localparam int AW_DEF  = 5;
    localparam int OPW_DEF = 4;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_OR   = 4'd2,
        ALU_AND  = 4'd3,
        ALU_SLT  = 4'd4,
        ALU_SLTU = 4'd5
    } alu_op_e;

    typedef enum logic [1:0] {
        FWD_REG = 2'd0,
        FWD_M   = 2'd1,
        FWD_W   = 2'd2
    } fwd_sel_e;

    localparam int REG_ZERO = 0;

endpackage

// File: rtl/alu_fwd_mux.sv
// Operand bypass mux: picks the newest value of one source register.
// Register $0 is never bypassed; M takes precedence over W on the same index.
module alu_fwd_mux
    import alu_issue_reg_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF
) (
    input  logic [AW-1:0] src_addr,
    input  logic [DW-1:0] src_val,
    input  logic          m_we,
    input  logic [AW-1:0] m_wa,
    input  logic [DW-1:0] m_wd,
    input  logic          w_we,
    input  logic [AW-1:0] w_wa,
    input  logic [DW-1:0] w_wd,
    output logic [DW-1:0] val
);

    localparam logic [AW-1:0] ZERO_ADDR = AW'(REG_ZERO);

    fwd_sel_e sel;

    // Choose the bypass source by stage age.
    always_comb begin
        sel = FWD_REG;
        if (src_addr != ZERO_ADDR) begin
            if (m_we && (m_wa == src_addr)) begin
                sel = FWD_M;
            end else if (w_we && (w_wa == src_addr)) begin
                sel = FWD_W;
            end
        end
    end

    // Steer the selected value.
    always_comb begin
        case (sel)
            FWD_M:   val = m_wd;
            FWD_W:   val = w_wd;
            default: val = src_val;
        endcase
    end

endmodule

// File: rtl/alu_issue_reg.sv
// D->E pipeline register in front of the ALU with M/W operand forwarding.
// Build option: ISSUE_FWD_EN enables forwarding and refresh of held operands
// during stall; without it the ALU sees the values read in D and the hazard
// unit is expected to stall instead.
module alu_issue_reg
    import alu_issue_reg_pkg::*;
#(
    parameter int DW  = DW_DEF,
    parameter int AW  = AW_DEF,
    parameter int OPW = OPW_DEF
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           stall,
    input  logic           flush,
    input  logic           d_valid,
    input  logic [DW-1:0]  d_pc,
    input  logic [OPW-1:0] d_alu_op,
    input  logic [AW-1:0]  d_rs_addr,
    input  logic [DW-1:0]  d_rs_val,
    input  logic [AW-1:0]  d_rt_addr,
    input  logic [DW-1:0]  d_rt_val,
    input  logic [DW-1:0]  d_imm,
    input  logic           d_use_imm,
    input  logic [AW-1:0]  d_wa,
    input  logic           d_ov_chk,
    input  logic           m_we,
    input  logic [AW-1:0]  m_wa,
    input  logic [DW-1:0]  m_wd,
    input  logic           w_we,
    input  logic [AW-1:0]  w_wa,
    input  logic [DW-1:0]  w_wd,
    output logic           e_valid,
    output logic [DW-1:0]  e_pc,
    output logic [OPW-1:0] alu_op,
    output logic [DW-1:0]  num1,
    output logic [DW-1:0]  num2,
    output logic [DW-1:0]  e_rt_fwd,
    output logic [AW-1:0]  e_wa,
    output logic           e_ov_chk
);

`ifdef ISSUE_FWD_EN
    localparam logic FWD_ON = 1'b1;
`else
    localparam logic FWD_ON = 1'b0;
`endif

    localparam logic [OPW-1:0] OP_BUBBLE = OPW'(ALU_ADD);

    logic           valid_q,   valid_d;
    logic [DW-1:0]  pc_q,      pc_d;
    logic [OPW-1:0] op_q,      op_d;
    logic [AW-1:0]  rs_addr_q, rs_addr_d;
    logic [DW-1:0]  rs_val_q,  rs_val_d;
    logic [AW-1:0]  rt_addr_q, rt_addr_d;
    logic [DW-1:0]  rt_val_q,  rt_val_d;
    logic [DW-1:0]  imm_q,     imm_d;
    logic           use_imm_q, use_imm_d;
    logic [AW-1:0]  wa_q,      wa_d;
    logic           ov_q,      ov_d;

    logic           m_we_g, w_we_g;
    logic [DW-1:0]  fwd_rs, fwd_rt;

    // With forwarding compiled out the write enables are tied low, so the muxes
    // return the stored values and stall refresh degenerates to a plain hold.
    assign m_we_g = m_we & FWD_ON;
    assign w_we_g = w_we & FWD_ON;

    alu_fwd_mux #(.DW(DW), .AW(AW)) u_fwd_rs (
        .src_addr (rs_addr_q),
        .src_val  (rs_val_q),
        .m_we     (m_we_g),
        .m_wa     (m_wa),
        .m_wd     (m_wd),
        .w_we     (w_we_g),
        .w_wa     (w_wa),
        .w_wd     (w_wd),
        .val      (fwd_rs)
    );

    alu_fwd_mux #(.DW(DW), .AW(AW)) u_fwd_rt (
        .src_addr (rt_addr_q),
        .src_val  (rt_val_q),
        .m_we     (m_we_g),
        .m_wa     (m_wa),
        .m_wd     (m_wd),
        .w_we     (w_we_g),
        .w_wa     (w_wa),
        .w_wd     (w_wd),
        .val      (fwd_rt)
    );

    // Next-state select: flush (or invalid D) -> bubble, stall -> hold/refresh, else load.
    always_comb begin
        valid_d   = valid_q;
        pc_d      = pc_q;
        op_d      = op_q;
        rs_addr_d = rs_addr_q;
        rs_val_d  = fwd_rs;
        rt_addr_d = rt_addr_q;
        rt_val_d  = fwd_rt;
        imm_d     = imm_q;
        use_imm_d = use_imm_q;
        wa_d      = wa_q;
        ov_d      = ov_q;
        if (flush || (!stall && !d_valid)) begin
            // Zeroed addresses keep a bubble from ever matching a forwarding source.
            valid_d   = 1'b0;
            pc_d      = d_pc;
            op_d      = OP_BUBBLE;
            rs_addr_d = '0;
            rs_val_d  = '0;
            rt_addr_d = '0;
            rt_val_d  = '0;
            imm_d     = '0;
            use_imm_d = 1'b0;
            wa_d      = '0;
            ov_d      = 1'b0;
        end else if (!stall) begin
            valid_d   = 1'b1;
            pc_d      = d_pc;
            op_d      = d_alu_op;
            rs_addr_d = d_rs_addr;
            rs_val_d  = d_rs_val;
            rt_addr_d = d_rt_addr;
            rt_val_d  = d_rt_val;
            imm_d     = d_imm;
            use_imm_d = d_use_imm;
            wa_d      = d_wa;
            ov_d      = d_ov_chk;
        end
    end

    // E-stage state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q   <= 1'b0;
            pc_q      <= '0;
            op_q      <= OP_BUBBLE;
            rs_addr_q <= '0;
            rs_val_q  <= '0;
            rt_addr_q <= '0;
            rt_val_q  <= '0;
            imm_q     <= '0;
            use_imm_q <= 1'b0;
            wa_q      <= '0;
            ov_q      <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            pc_q      <= pc_d;
            op_q      <= op_d;
            rs_addr_q <= rs_addr_d;
            rs_val_q  <= rs_val_d;
            rt_addr_q <= rt_addr_d;
            rt_val_q  <= rt_val_d;
            imm_q     <= imm_d;
            use_imm_q <= use_imm_d;
            wa_q      <= wa_d;
            ov_q      <= ov_d;
        end
    end

    // ALU-facing outputs.
    always_comb begin
        e_valid  = valid_q;
        e_pc     = pc_q;
        alu_op   = op_q;
        num1     = fwd_rs;
        num2     = use_imm_q ? imm_q : fwd_rt;
        e_rt_fwd = fwd_rt;
        e_wa     = wa_q;
        e_ov_chk = ov_q;
    end

endmodule
